// File: rtl/uart_intr_ctrl.sv
// ---------------------------------------------------------------------------
// uart_intr_ctrl
//
// Interrupt scheduler for the UART. It arbitrates four sources by fixed
// 16550 priority and registers the winning interrupt ID and the pending flag
// that the APB register block reads back through IIR.
//
//   priority  source                         intid
//   1 (high)  receiver line status (rls)     3'b011
//   2         receive data available (rda)   3'b010
//   3         character timeout (cti)        3'b110
//   4 (low)   THR empty (thr)                3'b001
//             none                           3'b000
//
// The block owns the THRE-interrupt pending flop and the FIFO
// character-timeout counter. rls and rda are purely level driven.
//
// Optional feature macro: UART_INTR_CTI_EN
//   defined     : character-timeout counter and flag are built; ID 3'b110
//                 can be reported.
//   not defined : counter and flag are absent; cti is tied low.
//
// Ports
//   pclk, presetn        clock, asynchronous active-low reset
//   erbi, etbei, elsi    IER enables (rda+cti, thre, line status)
//   oe, pe, fe, bi, dr   LSR error / data-ready bits
//   thre                 LSR THR empty
//   fifoen, rxfiftl      FCR FIFO enable and rx trigger select
//   rx_fifo_count        rx FIFO occupancy (0..16)
//   receive_done         one-cycle pulse per received character
//   rbr_rd_en            APB read of RBR
//   thr_wr_en            APB write of THR
//   iir_rd_en            APB read of IIR
//   baud_tick            16x oversample tick, one pclk wide
//   wls, stb, pen        LCR frame format
//   intid                registered interrupt ID
//   uart_intpt           registered interrupt pending, high active
// ---------------------------------------------------------------------------
module uart_intr_ctrl #(
   parameter int CNT_W      = 10,
   parameter int FIFO_CNT_W = 5
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  erbi,
   input  logic                  etbei,
   input  logic                  elsi,
   input  logic                  oe,
   input  logic                  pe,
   input  logic                  fe,
   input  logic                  bi,
   input  logic                  dr,
   input  logic                  thre,
   input  logic                  fifoen,
   input  logic [1:0]            rxfiftl,
   input  logic [FIFO_CNT_W-1:0] rx_fifo_count,
   input  logic                  receive_done,
   input  logic                  rbr_rd_en,
   input  logic                  thr_wr_en,
   input  logic                  iir_rd_en,
   input  logic                  baud_tick,
   input  logic [1:0]            wls,
   input  logic                  stb,
   input  logic                  pen,
   output logic [2:0]            intid,
   output logic                  uart_intpt
);

   localparam logic [2:0] ID_NONE = 3'b000;
   localparam logic [2:0] ID_THR  = 3'b001;
   localparam logic [2:0] ID_RDA  = 3'b010;
   localparam logic [2:0] ID_RLS  = 3'b011;
   localparam logic [2:0] ID_CTI  = 3'b110;

   logic                  rls;
   logic                  rda;
   logic                  cti;
   logic                  thr;
   logic [FIFO_CNT_W-1:0] trig;
   logic [2:0]            intid_next;

   // ------------------------------------------------------------------
   // Level-driven sources
   // ------------------------------------------------------------------
   always_comb begin
      case (rxfiftl)
         2'b00:   trig = FIFO_CNT_W'(1);
         2'b01:   trig = FIFO_CNT_W'(4);
         2'b10:   trig = FIFO_CNT_W'(8);
         default: trig = FIFO_CNT_W'(14);
      endcase
   end

   assign rls = elsi & (oe | pe | fe | bi);
   assign rda = erbi & (fifoen ? (rx_fifo_count >= trig) : dr);

   // ------------------------------------------------------------------
   // THRE pending flop
   // ------------------------------------------------------------------
   logic thre_en;
   logic thre_prev;
   logic thre_pend;
   logic thre_rise;

   assign thre_en   = thre & etbei;
   assign thre_rise = thre_en & ~thre_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         thre_prev <= 1'b0;
         thre_pend <= 1'b0;
      end else begin
         thre_prev <= thre_en;
         // THR write / disable beats a new edge; a new edge beats the IIR
         // read clear, so an edge arriving during the read is not lost.
         if (thr_wr_en || !etbei) begin
            thre_pend <= 1'b0;
         end else if (thre_rise) begin
            thre_pend <= 1'b1;
         end else if (iir_rd_en && (intid == ID_THR)) begin
            thre_pend <= 1'b0;
         end
      end
   end

   assign thr = etbei & thre_pend;

   // ------------------------------------------------------------------
   // Character timeout
   // ------------------------------------------------------------------
`ifdef UART_INTR_CTI_EN
   logic [CNT_W-1:0] cti_cnt;
   logic             cti_flag;
   logic [3:0]       frame_bits;
   logic [CNT_W-1:0] thresh_m1;
   logic             cnt_zero;
   logic             flag_clr;
   logic             cnt_run;
   logic             cnt_hit;

   // start + (5 + wls) data + parity + (1 + stb) stop = 7..12 bits
   assign frame_bits = 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
   // four characters at 16 ticks per bit = 64 ticks per frame bit
   assign thresh_m1  = CNT_W'({frame_bits, 6'b000000}) - CNT_W'(1);

   assign cnt_zero = receive_done | rbr_rd_en | ~fifoen |
                     (rx_fifo_count == '0);
   assign flag_clr = receive_done | rbr_rd_en | ~fifoen;
   assign cnt_run  = fifoen & (rx_fifo_count != '0) & ~cti_flag;
   // ">=" rather than "==" so a frame format shrunk mid-count below the
   // current count still fires on the next tick instead of wrapping.
   assign cnt_hit  = cnt_run & baud_tick & (cti_cnt >= thresh_m1);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cti_cnt  <= '0;
         cti_flag <= 1'b0;
      end else begin
         if (cnt_zero || cnt_hit) begin
            cti_cnt <= '0;
         end else if (cnt_run && baud_tick) begin
            cti_cnt <= cti_cnt + CNT_W'(1);
         end

         if (flag_clr) begin
            cti_flag <= 1'b0;
         end else if (cnt_hit) begin
            cti_flag <= 1'b1;
         end
      end
   end

   assign cti = erbi & fifoen & cti_flag;
`else
   assign cti = 1'b0;

   // Frame-format and timeout-related inputs have no load in this build.
   logic unused_cti_inputs;
   assign unused_cti_inputs = ^{baud_tick, receive_done, rbr_rd_en,
                                wls, stb, pen};
`endif

   // ------------------------------------------------------------------
   // Fixed-priority arbiter and registered outputs
   // ------------------------------------------------------------------
   // NOTE: the default assignment first keeps this block purely
   // combinational; a branch that skipped intid_next would infer a latch.
   always_comb begin
      intid_next = ID_NONE;
      if (rls) begin
         intid_next = ID_RLS;
      end else if (rda) begin
         intid_next = ID_RDA;
      end else if (cti) begin
         intid_next = ID_CTI;
      end else if (thr) begin
         intid_next = ID_THR;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         intid      <= ID_NONE;
         uart_intpt <= 1'b0;
      end else begin
         intid      <= intid_next;
         uart_intpt <= (intid_next != ID_NONE);
      end
   end

endmodule

// File: doc/uart_intr_ctrl.md
Name: uart_intr_ctrl

Overview:
- Interrupt scheduler for the UART. Arbitrates four interrupt sources by fixed priority: receiver line status, receive data available, character timeout and transmit holding register empty.
- Produces the registered interrupt ID and the pending flag (uart_intpt) that the APB register block reads back.
- Owns the THRE-interrupt pending flop and the FIFO character-timeout counter.
- Sits between the APB register interface (status and enable bits, read/write strobes) and the rx/tx datapath (FIFO level, receive_done, baud tick).

Parameters:
- CNT_W, 10, width of the character-timeout counter in baud ticks; must hold 64*12 = 768.
- FIFO_CNT_W, 5, width of rx_fifo_count; the FIFO holds 0..16 entries.

Ports:
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- erbi  in  1  enable receive-data-available and timeout interrupts
- etbei  in  1  enable THRE interrupt
- elsi  in  1  enable line-status interrupt
- oe  in  1  LSR overrun
- pe  in  1  LSR parity error
- fe  in  1  LSR framing error
- bi  in  1  LSR break
- dr  in  1  LSR data ready
- thre  in  1  LSR THR empty
- fifoen  in  1  FIFO mode
- rxfiftl  in  2  rx trigger select
- rx_fifo_count  in  FIFO_CNT_W  rx FIFO occupancy
- receive_done  in  1  one-cycle pulse when a character is received
- rbr_rd_en  in  1  APB read of RBR
- thr_wr_en  in  1  APB write of THR
- iir_rd_en  in  1  APB read of IIR (offset 0x8)
- baud_tick  in  1  16x oversample tick, one pclk wide
- wls  in  2  word length: 5 + wls data bits
- stb  in  1  second stop bit
- pen  in  1  parity enable
- intid  out  3  interrupt ID (registered)
- uart_intpt  out  1  interrupt pending, high active (registered)

Behaviour:
- Clock and reset: one clock, pclk; reset is asynchronous, active-low, on presetn. All state clears on reset: intid = 3'b000, uart_intpt = 0, thre_pend = 0, cti_flag = 0, counter = 0.
- Source conditions (combinational, this cycle):
  - rls = elsi & (oe|pe|fe|bi)
  - rda = erbi & (fifoen ? rx_fifo_count >= trig : dr)
  - trig: rxfiftl 00→1, 01→4, 10→8, 11→14
  - cti = erbi & fifoen & cti_flag
  - thr = etbei & thre_pend
- Priority and ID encoding, highest first: rls → 3'b011; rda → 3'b010; cti → 3'b110; thr → 3'b001; none → 3'b000.
- Output timing:
  - intid and uart_intpt register the arbiter result; they are valid one pclk after the source changes.
  - uart_intpt = (next intid != 0).
- thre_pend:
  - Set on a rising edge of (thre & etbei), using a registered previous value.
  - Cleared by thr_wr_en, by etbei = 0, or by iir_rd_en while the registered intid == 3'b001.
  - Same-cycle conflicts: thr_wr_en clear beats set; set beats the IIR-read clear.
  - A read of IIR showing a higher-priority ID does not clear thre_pend.
- Character timeout:
  - Frame bits F = 1 + (5+wls) + pen + (1+stb), range 7..12.
  - Threshold T = 64*F baud ticks, i.e. 4 characters.
  - The counter increments on baud_tick while fifoen & (rx_fifo_count != 0) & !cti_flag.
  - The counter zeroes on receive_done, rbr_rd_en, !fifoen, or rx_fifo_count == 0.
  - When counter == T-1 and baud_tick, set cti_flag and zero the counter.
  - cti_flag clears on rbr_rd_en, receive_done or !fifoen; a clear in the same cycle beats a set.
  - A change to wls/stb/pen mid-count takes effect at once. If the counter is already ≥ T, cti_flag sets on the next baud_tick.
- rls and rda are level-driven; they drop when the LSR bits or FIFO level drop. The block holds no state for them.
- Reset mid-count: counter and flags return to 0; no stale interrupt after reset.

Optional Feature:
- UART_INTR_CTI_EN
  - Defined: character-timeout counter and cti_flag are built; ID 3'b110 can be reported.
  - Not defined: counter and flag are absent; cti is tied 0. Behaviour is otherwise identical, including 16550 priorities among the remaining three sources.

Test Plan:
- THRE interrupt:
  - etbei 0→1 with thre = 1 → intid = 001, uart_intpt = 1 one cycle later.
  - Then iir_rd_en → intid = 000 next cycle.
  - Repeat, then thr_wr_en instead → also clears.
- Priority:
  - elsi = erbi = etbei = 1, dr = 1, thre_pend = 1, pe = 1 → intid = 011.
  - Drop pe → 010.
  - Drop dr → 001.
  - A read of IIR while intid = 011 leaves thre_pend set.
- FIFO trigger:
  - fifoen = 1, rxfiftl = 10, erbi = 1, count steps 7→8 → intid 000→010.
  - Count 8→7 → 000.
- Timeout:
  - fifoen = 1, wls = 11, pen = 0, stb = 0 (F = 10), count = 3, erbi = 1, no activity.
  - After 640 baud_ticks → intid = 110.
  - rbr_rd_en → 000.
  - A receive_done at tick 639 restarts the count with no interrupt.
- Conflict: etbei & thre rising edge in the same cycle as thr_wr_en → thre_pend stays 0, intid = 000.
- Reset: assert presetn low while cti_flag = 1 and intid = 110 → intid = 000, uart_intpt = 0 immediately. After release, the counter restarts from 0.
